// File: rtl/pwm_duty_ramp_if.sv
// Target-duty handshake between a requester and pwm_duty_ramp.
// master: drives tgt_valid/tgt_duty, slave: drives tgt_ready.
interface pwm_duty_ramp_if;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [7:0] tgt_duty;

    modport master (
        output tgt_valid,
        output tgt_duty,
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid,
        input  tgt_duty,
        output tgt_ready
    );
endinterface

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slews an 8-bit PWM duty toward a handshaked target,
// one step of STEP_SIZE every STEP_DIV clocks, never overshooting.
// Ports: clk, rst_n (async, active-low), tgt (slave handshake:
// tgt_valid/tgt_ready/tgt_duty), duty_cycle (registered duty),
// busy (ramp in progress), done (pulse when duty reaches target).
// Optional macro PWM_DUTY_RAMP_GAMMA_EN: duty_cycle becomes a
// registered gamma(current) and done is delayed one clock with it.
module pwm_duty_ramp #(
    parameter int unsigned STEP_DIV  = 1024,
    parameter int unsigned STEP_SIZE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_duty_ramp_if.slave tgt,
    output logic [7:0]     duty_cycle,
    output logic           busy,
    output logic           done
);
    localparam int unsigned PW =
        (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(STEP_DIV - 1);
    localparam logic [8:0]    STEP    = 9'(STEP_SIZE);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cur_q, cur_d;
    logic [7:0]        tgt_q, tgt_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic              done_q, done_d;
    logic              accept;
    logic              step_now;
    logic signed [8:0] diff;
    logic [8:0]        mag;
    logic [8:0]        amt;
    logic [7:0]        cur_step;

    assign accept   = tgt.tgt_valid & tgt.tgt_ready;
    assign step_now = (state_q == RAMP) && (pre_q == PRE_MAX);

    // 9-bit signed difference; step is clipped to the remaining
    // distance so the duty lands exactly on target.
    always_comb begin
        diff     = $signed({1'b0, tgt_q}) - $signed({1'b0, cur_q});
        mag      = diff[8] ? $unsigned(-diff) : $unsigned(diff);
        amt      = (mag < STEP) ? mag : STEP;
        cur_step = diff[8] ? (cur_q - amt[7:0])
                           : (cur_q + amt[7:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && (tgt.tgt_duty != cur_q)) begin
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (step_now && (cur_step == tgt_q)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tgt.tgt_ready = (state_q == IDLE);
        busy          = (state_q == RAMP);
    end

    always_comb begin
        tgt_d  = tgt_q;
        cur_d  = cur_q;
        pre_d  = pre_q;
        done_d = 1'b0;
        if (accept) begin
            tgt_d  = tgt.tgt_duty;
            pre_d  = '0;
            done_d = (tgt.tgt_duty == cur_q);
        end else if (state_q == RAMP) begin
            if (step_now) begin
                pre_d  = '0;
                cur_d  = cur_step;
                done_d = (cur_step == tgt_q);
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= '0;
            tgt_q  <= '0;
            pre_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cur_q  <= cur_d;
            tgt_q  <= tgt_d;
            pre_q  <= pre_d;
            done_q <= done_d;
        end
    end

`ifdef PWM_DUTY_RAMP_GAMMA_EN
    logic [7:0]  gam_q, gam_d;
    logic        dly_q, dly_d;
    logic [15:0] sq;

    // gamma(x) = (x*x + 255) >> 8 keeps 0->0 and 255->255
    always_comb begin
        sq    = {8'd0, cur_q} * {8'd0, cur_q};
        gam_d = 8'((sq + 16'd255) >> 8);
        dly_d = done_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gam_q <= '0;
            dly_q <= 1'b0;
        end else begin
            gam_q <= gam_d;
            dly_q <= dly_d;
        end
    end

    assign duty_cycle = gam_q;
    assign done       = dly_q;
`else
    assign duty_cycle = cur_q;
    assign done       = done_q;
`endif

endmodule
